// File: rtl/seq_divider_if.sv
// seq_divider_if: operand load, run control and result bundle for the sequential divider
interface seq_divider_if #(parameter int N = 8);
  logic LoadD;
  logic LoadV;
  logic Execute;
  logic [N-1:0] Din;
  logic [N-1:0] Qval;
  logic [N-1:0] Rval;
  logic [N-1:0] Mval;
  logic Busy;
  logic Done;
  logic DivByZero;
  modport master(output LoadD, LoadV, Execute, Din, input Qval, Rval, Mval, Busy, Done, DivByZero);
  modport slave(input LoadD, LoadV, Execute, Din, output Qval, Rval, Mval, Busy, Done, DivByZero);
endinterface

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one SHIFT and one SUB cycle per quotient bit
module seq_divider #(parameter int N = 8) (
  input logic Clk,
  input logic Reset,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(N);
  typedef enum logic [1:0] {IDLE, SHIFT, SUB, DONE} state_t;
  state_t state, state_n;
  logic [N-1:0] q, q_n, m, m_n;
  logic [N:0] r, r_n, trial;
  logic [CW-1:0] cnt, cnt_n;
  logic dz, dz_n;
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      q <= '0;
      r <= '0;
      m <= '0;
      cnt <= '0;
      dz <= 1'b0;
    end else begin
      state <= state_n;
      q <= q_n;
      r <= r_n;
      m <= m_n;
      cnt <= cnt_n;
      dz <= dz_n;
    end
  end
  always_comb begin
    state_n = state;
    q_n = q;
    r_n = r;
    m_n = m;
    cnt_n = cnt;
    dz_n = dz;
    trial = r - {1'b0, m};
    case (state)
      IDLE: begin
        if (bus.LoadD) q_n = bus.Din;
        if (bus.LoadV) m_n = bus.Din;
        if (bus.Execute) begin
          r_n = '0;
          cnt_n = '0;
          dz_n = (m == '0);
          state_n = (m == '0) ? DONE : SHIFT;
          // a zero divisor reports all-ones quotient and the dividend as remainder
          if (m == '0) begin
            q_n = '1;
            r_n = {1'b0, q};
          end
        end
      end
      SHIFT: begin
        {r_n, q_n} = {r[N-1:0], q, 1'b0};
        state_n = SUB;
      end
      SUB: begin
        if (r >= {1'b0, m}) begin
          r_n = trial;
          q_n = {q[N-1:1], 1'b1};
        end
        cnt_n = (cnt == CW'(N-1)) ? cnt : cnt + 1'b1;
        state_n = (cnt == CW'(N-1)) ? DONE : SHIFT;
      end
      DONE: state_n = bus.Execute ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.Qval = q;
  assign bus.Rval = r[N-1:0];
  assign bus.Mval = m;
  assign bus.Busy = (state == SHIFT) || (state == SUB);
  assign bus.Done = (state == DONE);
  assign bus.DivByZero = dz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors with hand-computed quotient, remainder and latency
module tb_seq_divider;
  logic Clk = 1'b0;
  logic Reset;
  int n_vec = 0;
  int n_bad = 0;
  seq_divider_if #(.N(8)) bus();
  seq_divider #(.N(8)) dut(.Clk(Clk), .Reset(Reset), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge Clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, ".q"}, 32'(bus.Qval), 0);
    check({tag, ".r"}, 32'(bus.Rval), 0);
    check({tag, ".m"}, 32'(bus.Mval), 0);
    check({tag, ".busy"}, 32'(bus.Busy), 0);
    check({tag, ".done"}, 32'(bus.Done), 0);
    check({tag, ".dz"}, 32'(bus.DivByZero), 0);
  endtask
  task automatic run(input string tag, input logic [7:0] d, input logic [7:0] v,
                     input logic [7:0] eq, input logic [7:0] er, input logic edz, input int lat);
    int k, bc;
    bus.LoadD = 1'b1;
    bus.Din = d;
    tick;
    bus.LoadD = 1'b0;
    bus.LoadV = 1'b1;
    bus.Din = v;
    tick;
    bus.LoadV = 1'b0;
    bus.Execute = 1'b1;
    tick;
    k = 0;
    bc = 0;
    while (!bus.Done && k < 40) begin
      bc += int'(bus.Busy);
      tick;
      k++;
    end
    check({tag, ".lat"}, 32'(k), 32'(lat));
    check({tag, ".busy"}, 32'(bc), 32'(lat));
    check({tag, ".q"}, 32'(bus.Qval), 32'(eq));
    check({tag, ".r"}, 32'(bus.Rval), 32'(er));
    check({tag, ".m"}, 32'(bus.Mval), 32'(v));
    check({tag, ".dz"}, 32'(bus.DivByZero), 32'(edz));
  endtask
  task automatic release_exec(input string tag);
    bus.Execute = 1'b0;
    tick;
    check({tag, ".idle"}, 32'({bus.Done, bus.Busy}), 0);
  endtask
  initial begin
    Reset = 1'b0;
    bus.LoadD = 1'($urandom);
    bus.LoadV = 1'($urandom);
    bus.Execute = 1'($urandom);
    bus.Din = 8'($urandom);
    tick;
    Reset = 1'b1;
    bus.LoadD = 1'b0;
    bus.LoadV = 1'b0;
    bus.Execute = 1'b0;
    check_zero("rst");
    tick;
    run("c8_07", 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 16);
    release_exec("c8_07");
    run("ff_01", 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 16);
    release_exec("ff_01");
    run("ff_ff", 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 16);
    release_exec("ff_ff");
    run("05_09", 8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 16);
    release_exec("05_09");
    run("00_80", 8'h00, 8'h80, 8'h00, 8'h00, 1'b0, 16);
    release_exec("00_80");
    run("fe_80", 8'hFE, 8'h80, 8'h01, 8'h7E, 1'b0, 16);
    release_exec("fe_80");
    run("dz", 8'h2A, 8'h00, 8'hFF, 8'h2A, 1'b1, 0);
    release_exec("dz");
    run("dz_clr", 8'h64, 8'h0A, 8'h0A, 8'h00, 1'b0, 16);
    for (int i = 0; i < 10; i++) begin
      bus.LoadD = 1'(i);
      bus.LoadV = 1'(~i);
      bus.Din = 8'h33;
      tick;
    end
    bus.LoadD = 1'b0;
    bus.LoadV = 1'b0;
    check("hold.done", 32'(bus.Done), 1);
    check("hold.q", 32'(bus.Qval), 32'h0A);
    check("hold.r", 32'(bus.Rval), 32'h00);
    check("hold.m", 32'(bus.Mval), 32'h0A);
    release_exec("hold");
    run("repress", 8'h64, 8'h0A, 8'h0A, 8'h00, 1'b0, 16);
    release_exec("repress");
    bus.LoadD = 1'b1;
    bus.Din = 8'd200;
    tick;
    bus.LoadD = 1'b0;
    bus.LoadV = 1'b1;
    bus.Din = 8'd7;
    tick;
    bus.LoadV = 1'b0;
    bus.Execute = 1'b1;
    tick;
    for (int i = 1; i < 7; i++) tick;
    check("mid.busy", 32'(bus.Busy), 1);
    Reset = 1'b0;
    tick;
    Reset = 1'b1;
    bus.Execute = 1'b0;
    check_zero("mid");
    tick;
    check("mid.idle", 32'({bus.Done, bus.Busy}), 0);
    run("after_rst", 8'hC8, 8'h07, 8'h1C, 8'h04, 1'b0, 16);
    release_exec("after_rst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
